// File: rtl/gpio_pkg.sv
// Shared register map for the GPIO controller (gpio_ctrl and gpio_sync_edge).
package gpio_pkg;

  localparam int unsigned GPIO_DDR      = 0;
  localparam int unsigned GPIO_PVL      = 1;
  localparam int unsigned GPIO_PIN      = 2;
  localparam int unsigned GPIO_SET      = 3;
  localparam int unsigned GPIO_CLR      = 4;
  localparam int unsigned GPIO_TGL      = 5;
  localparam int unsigned GPIO_RISE     = 6;
  localparam int unsigned GPIO_FALL     = 7;
  localparam int unsigned GPIO_FLAG     = 8;
  localparam int unsigned GPIO_NUM_REGS = 9;

  // Offsets that return 0 on read but still acknowledge with outEn.
  function automatic logic gpio_is_strobe(input int unsigned off);
    return (off == GPIO_SET) || (off == GPIO_CLR) || (off == GPIO_TGL);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser, optional debounce filter and edge detector.
// Debounce is compiled in only when GPIO_DEBOUNCE_EN is defined.
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  stable;
  logic [WIDTH-1:0]                  filt;
  logic [WIDTH-1:0]                  hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign stable = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           deb_q, deb_d;

  // Counter tracks consecutive cycles the input disagrees with the filtered value.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (stable[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntW'(DEB_CYCLES - 1)) begin
        deb_d[i] = stable[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign filt = deb_q;
`else
  localparam int unsigned unused_deb_cycles = DEB_CYCLES;

  assign filt = stable;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= filt;
    end
  end

  assign sync_o = filt;
  assign rise_o = filt & ~hist_q;
  assign fall_o = ~filt & hist_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: direction/value registers, atomic set/clear/toggle,
// per-pin edge flags with a combined irq. Optional input debounce via GPIO_DEBOUNCE_EN.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned       PORT_SIZE   = 8,
  parameter int unsigned       XLEN        = 32,
  parameter int unsigned       ADDRW       = 11,
  parameter logic [ADDRW-1:0]  BASE_ADDR   = 11'h404,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       DEB_CYCLES  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRW-1:0]     addr,
  input  logic [XLEN-1:0]      wrData,
  input  logic                 wrEn,
  input  logic                 rdEn,
  output logic [XLEN-1:0]      dataOut,
  output logic                 outEn,
  output logic [PORT_SIZE-1:0] ddr,
  output logic [PORT_SIZE-1:0] pvl,
  input  logic [PORT_SIZE-1:0] pin,
  output logic                 irq
);

  logic [PORT_SIZE-1:0] ddr_q, ddr_d;
  logic [PORT_SIZE-1:0] pvl_q, pvl_d;
  logic [PORT_SIZE-1:0] rise_en_q, rise_en_d;
  logic [PORT_SIZE-1:0] fall_en_q, fall_en_d;
  logic [PORT_SIZE-1:0] flag_q, flag_d;
  logic [XLEN-1:0]      dout_q, dout_d;
  logic                 oen_q, oen_d;

  logic [PORT_SIZE-1:0] pin_s, rise, fall;
  logic [PORT_SIZE-1:0] wr_bits, w1c, rd_val;
  logic [ADDRW-1:0]     off;
  logic [3:0]           idx;
  logic                 in_map;
  logic                 unused_wdata;

  gpio_sync_edge #(
    .WIDTH       (PORT_SIZE),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (pin),
    .sync_o (pin_s),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Lower-bound check guards against the subtraction wrapping below BASE_ADDR.
  assign off          = addr - BASE_ADDR;
  assign in_map       = (addr >= BASE_ADDR) && (off < ADDRW'(GPIO_NUM_REGS));
  assign idx          = off[3:0];
  assign wr_bits      = wrData[PORT_SIZE-1:0];
  assign unused_wdata = ^wrData;

  always_comb begin
    rd_val = '0;
    case (idx)
      4'(GPIO_DDR):  rd_val = ddr_q;
      4'(GPIO_PVL):  rd_val = pvl_q;
      4'(GPIO_PIN):  rd_val = pin_s;
      4'(GPIO_RISE): rd_val = rise_en_q;
      4'(GPIO_FALL): rd_val = fall_en_q;
      4'(GPIO_FLAG): rd_val = flag_q;
      default:       rd_val = '0;
    endcase
  end

  always_comb begin
    ddr_d     = ddr_q;
    pvl_d     = pvl_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wrEn && in_map) begin
      case (idx)
        4'(GPIO_DDR):  ddr_d     = wr_bits;
        4'(GPIO_PVL):  pvl_d     = wr_bits;
        4'(GPIO_SET):  pvl_d     = pvl_q | wr_bits;
        4'(GPIO_CLR):  pvl_d     = pvl_q & ~wr_bits;
        4'(GPIO_TGL):  pvl_d     = pvl_q ^ wr_bits;
        4'(GPIO_RISE): rise_en_d = wr_bits;
        4'(GPIO_FALL): fall_en_d = wr_bits;
        4'(GPIO_FLAG): w1c       = wr_bits;
        default:       ;
      endcase
    end
    // A new edge overrides a simultaneous clear of the same bit.
    flag_d = (flag_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  assign oen_d  = rdEn && in_map;
  assign dout_d = oen_d ? XLEN'(rd_val) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr_q     <= '0;
      pvl_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      flag_q    <= '0;
      dout_q    <= '0;
      oen_q     <= 1'b0;
    end else begin
      ddr_q     <= ddr_d;
      pvl_q     <= pvl_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      flag_q    <= flag_d;
      dout_q    <= dout_d;
      oen_q     <= oen_d;
    end
  end

  assign ddr     = ddr_q;
  assign pvl     = pvl_q;
  assign dataOut = dout_q;
  assign outEn   = oen_q;
  assign irq     = |(flag_q & (rise_en_q | fall_en_q));

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Parametrised memory-mapped GPIO controller that replaces the fixed 8-bit io_port. It sits on the core data bus beside ram_Controller and uart, and supports a generic pin count. It adds synchronised inputs, atomic set/clear/toggle of output values, and per-pin rising/falling edge interrupts with a single combined irq line. Tri-state buffers stay outside the block, in the SoC top; this block only drives pvl and ddr and samples pin.

Parameters:
PORT_SIZE, 8, number of GPIO pins (1..32)
XLEN, 32, data bus width
ADDRW, 11, width of the bus address compared by the decoder
BASE_ADDR, 11'h404, address of register 0; register k sits at BASE_ADDR+k
SYNC_STAGES, 2, input synchroniser depth (>=2)
DEB_CYCLES, 1000, debounce stability count (used only with GPIO_DEBOUNCE_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
addr  in  ADDRW  bus address
wrData  in  XLEN  write data
wrEn  in  1  bus write strobe
rdEn  in  1  bus read strobe
dataOut  out  XLEN  read data, registered
outEn  out  1  read data valid
ddr  out  PORT_SIZE  direction, 1 = output
pvl  out  PORT_SIZE  output value
pin  in  PORT_SIZE  raw pad input, asynchronous
irq  out  1  OR of (FLAG & (RISE_EN|FALL_EN))

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting rst immediately clears DDR, PVL, RISE_EN, FALL_EN, FLAG, the synchroniser and edge history, dataOut, outEn and irq.
  - Reset mid-access aborts the access; no write takes effect.
- Register map (offset from BASE_ADDR); only bits [PORT_SIZE-1:0] are used, upper bits write-ignored and read as 0:
  - 0 DDR: read/write.
  - 1 PVL: read/write.
  - 2 PIN: read-only, synchronised (or debounced) input value.
  - 3 SET: write-only; PVL |= wrData.
  - 4 CLR: write-only; PVL &= ~wrData.
  - 5 TGL: write-only; PVL ^= wrData.
  - 6 RISE_EN: read/write.
  - 7 FALL_EN: read/write.
  - 8 FLAG: read; writing 1 clears the bit (W1C).
- Writes: take effect on the clk edge where wrEn=1 and the address matches. Writes to unmapped offsets are ignored.
- Reads: rdEn with an address match gives dataOut and outEn=1 on the following cycle, for exactly one cycle.
  - SET, CLR and TGL read as 0 with outEn=1.
  - Unmapped offsets keep outEn=0 and dataOut=0.
  - outEn=0 in any cycle without a matching read.
- Input path: SYNC_STAGES flip-flop synchroniser per pin, then a history register.
  - rise = s & ~h; fall = ~s & h, where s is the synchronised value and h the previous value.
  - Latency from pin change to PIN read value is SYNC_STAGES cycles.
  - FLAG sets SYNC_STAGES+1 cycles after the pad change.
- Flag update: FLAG_next = (FLAG & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - If an edge and a W1C hit the same bit in the same cycle, the set wins.
  - An edge on a bit whose enable is 0 does not set its flag.
- Pins with DDR=1 are still sampled, so a pin's own output transitions can raise flags.
- irq is combinational from registers only, so it has no pad-to-irq combinational path.
- Simultaneous wrEn and rdEn to the same register: the read returns the pre-write value.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined: each pin gets a counter of width $clog2(DEB_CYCLES+1) between the synchroniser and the history register.
  - The debounced value updates only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles.
  - The counter resets to 0 whenever the input matches the debounced value.
  - Edges and PIN are derived from the debounced value.
  - Counters and debounced values reset to 0.
- Undefined: no counters; the synchronised value feeds edge detection directly, and DEB_CYCLES is unused.

Decomposition:
- Package gpio_pkg holds:
  - register offset localparams: GPIO_DDR=0, GPIO_PVL=1, GPIO_PIN=2, GPIO_SET=3, GPIO_CLR=4, GPIO_TGL=5, GPIO_RISE=6, GPIO_FALL=7, GPIO_FLAG=8;
  - GPIO_NUM_REGS=9.
- Sub-module gpio_sync_edge: per-bus synchroniser, optional debounce and history register. It outputs sync, rise and fall vectors, and is instantiated once at PORT_SIZE width.

Test Plan:
1. Reset:
   - Assert rst mid-write of DDR=0xFF -> ddr=0x00, pvl=0x00, irq=0, outEn=0 immediately.
   - After release, reading DDR returns 0x00.
2. Atomic PVL updates:
   - Write PVL=0xA5, SET 0x0F, CLR 0x81, TGL 0xFF -> pvl sequence 0xA5, 0xAF, 0x2E, 0xD1.
   - Reading PVL gives 0xD1 with outEn one cycle after rdEn.
3. Rising-edge interrupt:
   - RISE_EN=0x01; pin[0] goes 0->1 at cycle t -> FLAG=0x01 and irq=1 at t+3 (SYNC_STAGES=2).
   - W1C 0x01 -> irq=0.
   - pin[1] rising with RISE_EN[1]=0 -> FLAG unchanged.
4. Falling edge plus collision:
   - FALL_EN=0x04; W1C 0x04 issued in the same cycle pin[2]'s fall is detected -> FLAG[2] remains 1.
5. Bus decode:
   - Read offset 9 and address BASE_ADDR-1 -> outEn stays 0.
   - Write offset 12 -> no register changes.
   - Read SET -> dataOut=0 with outEn=1.
6. Debounce (GPIO_DEBOUNCE_EN, DEB_CYCLES=4):
   - pin[3] glitches high for 3 cycles -> no flag, PIN[3]=0.
   - pin[3] held high for 10 cycles -> PIN[3]=1 after 2+4 cycles, and exactly one rising flag.
